async_fifo_core: RTL and testbench

- Single-clock synchronous FIFO: 8-bit data, 16 entries by default.
- Registered read data; full and empty status flags; single-cycle overflow and underflow error pulses.
- Sits between a producer and a consumer in the same clock domain as an elastic buffer.
- Keeps the write/read port naming of the existing FIFO family.

---
 rtl/async_fifo_core.sv | 89 ++++++++
 tb/tb_async_fifo_core.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/async_fifo_core.sv
// Single-clock FIFO with registered read data, full/empty flags and registered error pulses.
// Define ASYNC_FIFO_COUNT_EN to add the occupancy output port 'count'.
module async_fifo_core #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  empty,
    output logic                  overflow,
`ifdef ASYNC_FIFO_COUNT_EN
    output logic                  underflow,
    output logic [ADDR_WIDTH:0]   count
`else
    output logic                  underflow
`endif
);

    typedef logic [ADDR_WIDTH:0]   ptr_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;

    localparam ptr_t PTR_ONE = ptr_t'(1);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    ptr_t  wr_ptr;
    ptr_t  rd_ptr;
    addr_t wr_addr;
    addr_t rd_addr;
    logic  wr_accept;
    logic  rd_accept;

    assign wr_addr = wr_ptr[ADDR_WIDTH-1:0];
    assign rd_addr = rd_ptr[ADDR_WIDTH-1:0];

    // The wrap bit distinguishes a full FIFO from an empty one when the low bits match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_addr == rd_addr) && (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);

    assign wr_accept = wr_en && !full;
    assign rd_accept = rd_en && !empty;

`ifdef ASYNC_FIFO_COUNT_EN
    assign count = wr_ptr - rd_ptr;
`endif

    // NOTE: storage has no reset so it maps onto plain RAM; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_addr] <= din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
        end else if (wr_accept) begin
            wr_ptr <= wr_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            dout   <= '0;
        end else if (rd_accept) begin
            rd_ptr <= rd_ptr + PTR_ONE;
            dout   <= mem[rd_addr];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= wr_en && full;
            underflow <= rd_en && empty;
        end
    end

endmodule

// File: tb/tb_async_fifo_core.sv
// Directed self-checking bench for async_fifo_core: ordering, flag boundaries, error pulses, async reset.
module tb_async_fifo_core;

    localparam int DATA_WIDTH = 8;
    localparam int FIFO_DEPTH = 16;
    localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH);

    logic                  clk;
    logic                  reset;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] din;
    logic                  full;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] dout;
    logic                  empty;
    logic                  overflow;
    logic                  underflow;
`ifdef ASYNC_FIFO_COUNT_EN
    logic [ADDR_WIDTH:0]   count;
`endif

    int checks = 0;
    int errors = 0;

    async_fifo_core #(
        .DATA_WIDTH(DATA_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .din      (din),
        .full     (full),
        .rd_en    (rd_en),
        .dout     (dout),
        .empty    (empty),
        .overflow (overflow),
`ifdef ASYNC_FIFO_COUNT_EN
        .underflow(underflow),
        .count    (count)
`else
        .underflow(underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one rising edge and settle; outputs then reflect that edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ov_pulses;
        reset = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = '0;
        repeat (2) cycle();

        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_dout", 32'(dout), 32'h0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_udf", 32'(underflow), 32'd0);
        reset = 1'b0;
        cycle();

        // Single word round trip.
        wr_en = 1'b1; din = 8'hA5;
        cycle();
        wr_en = 1'b0;
        check("t1_not_empty", 32'(empty), 32'd0);
        rd_en = 1'b1;
        cycle();
        rd_en = 1'b0;
        check("t1_dout", 32'(dout), 32'hA5);
        check("t1_empty", 32'(empty), 32'd1);

        // Fill to exactly 16, then drain in order.
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; din = 8'(i);
            cycle();
            if (i == 14) check("t2_full_at_15", 32'(full), 32'd0);
        end
        wr_en = 1'b0;
        check("t2_full_at_16", 32'(full), 32'd1);
        for (int i = 0; i < 16; i++) begin
            rd_en = 1'b1;
            cycle();
            check($sformatf("t2_dout_%0d", i), 32'(dout), 32'(i));
        end
        rd_en = 1'b0;
        check("t2_empty", 32'(empty), 32'd1);
        check("t2_no_udf", 32'(underflow), 32'd0);

        // 20 writes from empty: last 4 dropped, each raising one overflow pulse.
        ov_pulses = 0;
        for (int i = 0; i < 20; i++) begin
            wr_en = 1'b1; din = 8'(i);
            cycle();
            if (overflow) ov_pulses++;
        end
        wr_en = 1'b0;
        cycle();
        if (overflow) ov_pulses++;
        check("t3_ovf_pulses", 32'(ov_pulses), 32'd4);
        check("t3_full", 32'(full), 32'd1);

        // 17 reads from full: 0..15 then one rejected read.
        for (int i = 0; i < 16; i++) begin
            rd_en = 1'b1;
            cycle();
            check($sformatf("t4_dout_%0d", i), 32'(dout), 32'(i));
        end
        check("t4_no_udf_yet", 32'(underflow), 32'd0);
        cycle();
        rd_en = 1'b0;
        check("t4_udf", 32'(underflow), 32'd1);
        check("t4_dout_hold", 32'(dout), 32'h0F);
        check("t4_empty", 32'(empty), 32'd1);
        cycle();
        check("t4_udf_single", 32'(underflow), 32'd0);

        // Streaming with one word of prefill: occupancy stays at 1.
        wr_en = 1'b1; din = 8'hEE;
        cycle();
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; rd_en = 1'b1; din = 8'(8'h10 + i);
            cycle();
            check($sformatf("t5_dout_%0d", i), 32'(dout), (i == 0) ? 32'hEE : 32'(8'h10 + i - 1));
            check($sformatf("t5_flags_%0d", i),
                  {28'd0, empty, full, overflow, underflow}, 32'd0);
`ifdef ASYNC_FIFO_COUNT_EN
            check($sformatf("t5_count_%0d", i), 32'(count), 32'd1);
`endif
        end
        wr_en = 1'b0;
        cycle();
        rd_en = 1'b0;
        check("t5_last", 32'(dout), 32'h1F);
        check("t5_empty", 32'(empty), 32'd1);

        // Simultaneous at empty: write taken, read rejected, no fall-through.
        wr_en = 1'b1; rd_en = 1'b1; din = 8'h77;
        cycle();
        rd_en = 1'b0;
        check("t7_empty_udf", 32'(underflow), 32'd1);
        check("t7_empty_dout", 32'(dout), 32'h1F);
        check("t7_empty_flag", 32'(empty), 32'd0);
        for (int i = 0; i < 15; i++) begin
            din = 8'(8'h80 + i);
            cycle();
        end
        check("t7_full", 32'(full), 32'd1);

        // Simultaneous at full: read taken, write dropped.
        rd_en = 1'b1; din = 8'hFF;
        cycle();
        wr_en = 1'b0;
        check("t7_full_ovf", 32'(overflow), 32'd1);
        check("t7_full_dout", 32'(dout), 32'h77);
        check("t7_full_flag", 32'(full), 32'd0);
        for (int i = 0; i < 15; i++) begin
            cycle();
            check($sformatf("t7_drain_%0d", i), 32'(dout), 32'(8'h80 + i));
        end
        rd_en = 1'b0;
        check("t7_drained", 32'(empty), 32'd1);

        // Mid-cycle async reset with 5 words stored and a nonzero dout.
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; din = 8'(8'h50 + i);
            cycle();
        end
        wr_en = 1'b0; rd_en = 1'b1;
        cycle();
        rd_en = 1'b0;
        check("t6_pre_dout", 32'(dout), 32'h50);
        #3 reset = 1'b1;
        #1;
        check("t6_rst_empty", 32'(empty), 32'd1);
        check("t6_rst_full", 32'(full), 32'd0);
        check("t6_rst_dout", 32'(dout), 32'h0);
`ifdef ASYNC_FIFO_COUNT_EN
        check("t6_rst_count", 32'(count), 32'd0);
`endif
        cycle();
        reset = 1'b0;
        cycle();
        wr_en = 1'b1; din = 8'h3C;
        cycle();
        wr_en = 1'b0; rd_en = 1'b1;
        cycle();
        rd_en = 1'b0;
        check("t6_dout", 32'(dout), 32'h3C);
        check("t6_empty", 32'(empty), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
